retire_rat: RTL and testbench
=============================

# retire_rat

Retirement register alias table (R-RAT) sitting directly downstream of the ROB/retire stage. It consumes one committed register mapping per cycle, updates the architectural-to-physical map, and buffers the displaced physical register in a small FIFO. That FIFO drains to the rename free list over a valid/ready handshake. On a recovery request it walks the committed map one entry per cycle so the front-end RAT can be rebuilt.

## Interface
- NUM_ARCH_REGS, default `PROJ_NUM_ARCH_REGS: architectural register count. LOG_ARCH = $clog2 of this value.
- NUM_PHYS_REGS, default `PROJ_NUM_PHYS_REGS: physical register count. LOG_PHYS = $clog2 of this value.
- FREE_DEPTH, default 8: free-FIFO entries. Must be a power of two, ≥2.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Commit_valid_IN  in  1  ROB commit with register update (ROB ReadyCommit & RegUpdate).
- Commit_arch_IN  in  LOG_ARCH  architectural destination.
- Commit_phys_IN  in  LOG_PHYS  newly committed physical register.
- Stall_OUT  out  1  commit not accepted this cycle; the ROB holds its head.
- Free_valid_OUT  out  1  FIFO head is valid.
- Free_reg_OUT  out  LOG_PHYS  physical register being returned.
- Free_ready_IN  in  1  free list accepts; a pop occurs when valid & ready.
- Recover_IN  in  1  start a map walk (single-cycle pulse is sufficient).
- Recover_busy_OUT  out  1  walk in progress.
- Copy_valid_OUT  out  1  Copy_arch_OUT/Copy_phys_OUT hold a map entry.
- Copy_arch_OUT  out  LOG_ARCH  walk index.
- Copy_phys_OUT  out  LOG_PHYS  map[index].

## Operation
- Reset (async, RESET=0):
  - map[i] = i for every i.
  - FIFO empty: head=tail=0, count=0.
  - FSM in IDLE, walk index = 0.
  - All outputs 0.
- Stall_OUT = (count == FREE_DEPTH) | (state == WALK). It is derived from registered state only and does not depend on a pop in the same cycle.
- A commit is accepted when Commit_valid_IN & !Stall_OUT:
  - old = map[Commit_arch_IN]; map[Commit_arch_IN] <= Commit_phys_IN; old is pushed to the FIFO.
  - If old == Commit_phys_IN, the map is written but nothing is pushed. This prevents freeing a live register.
- Stalled commits are ignored entirely. The ROB re-presents the same commit next cycle.
- FIFO:
  - Push and pop in the same cycle are both applied; count is unchanged.
  - Pointers wrap modulo FREE_DEPTH. count is LOG2(FREE_DEPTH)+1 bits wide.
  - Free_valid_OUT = (count != 0). Free_reg_OUT = entry at head; its value is a don't-care when not valid.
- FSM states:
  - IDLE: Recover_IN=1 → WALK with index=0. A commit accepted in the same cycle is applied first, so the walk sees the updated map.
  - WALK: each cycle Copy_valid_OUT=1, Copy_arch_OUT=index, Copy_phys_OUT=map[index], then index++. After index == NUM_ARCH_REGS-1 → IDLE. Recover_IN is ignored while in WALK.
  - Recover_busy_OUT = (state == WALK).
- The FIFO keeps draining during WALK.
- Reset mid-walk aborts to IDLE. Pending FIFO entries are discarded.

## Timing
- Commit accepted in cycle N:
  - Map updated at edge N+1.
  - Free_valid_OUT high in N+1 if the FIFO was empty.
- Walk:
  - Recover_IN sampled at edge N; Copy_valid_OUT is high for cycles N+1 … N+NUM_ARCH_REGS.
  - Recover_busy_OUT is high over exactly those cycles.
  - Stall_OUT drops in cycle N+NUM_ARCH_REGS+1.
- Full FIFO with a pop in cycle N: Stall_OUT still high in N, low in N+1.
- Free_reg_OUT is stable while Free_valid_OUT & !Free_ready_IN.

## Configuration
- RRAT_ZERO_REG_EN defined:
  - Architectural register 0 is hardwired. map[0] stays 0 and is never written.
  - A commit to arch 0 pushes Commit_phys_IN itself into the FIFO (immediate free).
  - The walk still reports map[0]=0.
- RRAT_ZERO_REG_EN undefined: arch 0 is treated like every other register.

## Structure
- Shared package retire_pkg:
  - LOG_ARCH/LOG_PHYS width macros.
  - FSM state encoding (IDLE=1'b0, WALK=1'b1).
  - Free-FIFO depth default.
- Sub-module free_reg_fifo: parameterized LOG_PHYS-wide, FREE_DEPTH-entry FIFO.
  - Ports: push/data in, valid/data/ready out, full flag out, asynchronous active-low reset.
  - The retire_rat top holds the map array, the commit logic and the walk FSM.

## Test plan
- Reset then Recover_IN → 32 cycles of Copy_phys_OUT = Copy_arch_OUT = 0..31 (NUM_ARCH_REGS=32); Free_valid_OUT stays 0.
- Commit (arch 5, phys 40) with Free_ready_IN=1 → next cycle Free_valid_OUT=1, Free_reg_OUT=5; a subsequent walk reports map[5]=40.
- Free_ready_IN=0, 8 distinct commits → Stall_OUT=1 after the 8th. A 9th commit (arch 7, phys 50) is ignored: map[7] is unchanged. One pop, then the 9th is accepted one cycle later.
- Commit and Recover_IN in the same cycle (arch 3, phys 60):
  - Walk reports map[3]=60.
  - Commits presented during the walk see Stall_OUT=1.
  - Stall_OUT=0 one cycle after the last copy.
- RESET asserted at walk index 10 → all outputs 0 immediately; after release, map[10]=10 and the FIFO is empty.
- RRAT_ZERO_REG_EN: commit (arch 0, phys 45) → Free_reg_OUT=45; the walk reports map[0]=0.

Source files
------------

// File: rtl/retire_pkg.sv
// retire_pkg: shared widths, walk FSM encoding and free-FIFO default for the retirement RAT
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 64
`endif
`define RRAT_LOG_ARCH $clog2(`PROJ_NUM_ARCH_REGS)
`define RRAT_LOG_PHYS $clog2(`PROJ_NUM_PHYS_REGS)

package retire_pkg;
  localparam int DEF_LOG_ARCH = `RRAT_LOG_ARCH;
  localparam int DEF_LOG_PHYS = `RRAT_LOG_PHYS;
  localparam int DEF_FREE_DEPTH = 8;
  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} walk_state_e;
endpackage

// File: rtl/free_reg_fifo.sv
// free_reg_fifo: DEPTH-entry FIFO of displaced physical registers draining to the free list
module free_reg_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_full
);
  localparam int LOG_D = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LOG_D-1:0] r_head, r_tail;
  logic [LOG_D:0]   r_count;
  logic             w_push, w_pop;
  assign o_valid = r_count != '0;
  assign o_full  = r_count == (LOG_D+1)'(DEPTH);
  assign o_data  = r_mem[r_head];
  assign w_push  = i_push & !o_full;
  assign w_pop   = o_valid & i_ready;
  // pointers wrap naturally since DEPTH is a power of two; push and pop may coincide
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (LOG_D+1)'(w_push) - (LOG_D+1)'(w_pop);
    end
  end
endmodule

// File: rtl/retire_rat.sv
// retire_rat: retirement RAT with free-register FIFO and recovery map walk (option: RRAT_ZERO_REG_EN hardwires arch 0)
module retire_rat
  import retire_pkg::*;
#(
  parameter int NUM_ARCH_REGS = `PROJ_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = `PROJ_NUM_PHYS_REGS,
  parameter int FREE_DEPTH    = DEF_FREE_DEPTH,
  localparam int LOG_ARCH     = $clog2(NUM_ARCH_REGS),
  localparam int LOG_PHYS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Commit_valid_IN,
  input  logic [LOG_ARCH-1:0] Commit_arch_IN,
  input  logic [LOG_PHYS-1:0] Commit_phys_IN,
  output logic                Stall_OUT,
  output logic                Free_valid_OUT,
  output logic [LOG_PHYS-1:0] Free_reg_OUT,
  input  logic                Free_ready_IN,
  input  logic                Recover_IN,
  output logic                Recover_busy_OUT,
  output logic                Copy_valid_OUT,
  output logic [LOG_ARCH-1:0] Copy_arch_OUT,
  output logic [LOG_PHYS-1:0] Copy_phys_OUT
);
  logic [LOG_PHYS-1:0] r_map [NUM_ARCH_REGS];
  walk_state_e         r_state, w_next;
  logic [LOG_ARCH-1:0] r_idx;
  logic                w_full, w_accept, w_we, w_push, w_last;
  logic [LOG_PHYS-1:0] w_old, w_push_data;
  assign w_accept = Commit_valid_IN & !Stall_OUT;
  assign w_old    = r_map[Commit_arch_IN];
  assign w_last   = r_idx == LOG_ARCH'(NUM_ARCH_REGS - 1);
`ifdef RRAT_ZERO_REG_EN
  logic w_zero;
  assign w_zero      = Commit_arch_IN == '0;
  assign w_we        = w_accept & !w_zero;
  assign w_push      = w_accept & (w_zero | (w_old != Commit_phys_IN));
  assign w_push_data = w_zero ? Commit_phys_IN : w_old;
`else
  assign w_we        = w_accept;
  assign w_push      = w_accept & (w_old != Commit_phys_IN);
  assign w_push_data = w_old;
`endif
  // committed map: identity at reset, one accepted commit written per cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) for (int i = 0; i < NUM_ARCH_REGS; i++) r_map[i] <= LOG_PHYS'(i);
    else if (w_we) r_map[Commit_arch_IN] <= Commit_phys_IN;
  end
  // walk state and index register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= (r_state == WALK && !w_last) ? r_idx + 1'b1 : '0;
    end
  end
  // next state: start on Recover_IN, finish after the last architectural register
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = Recover_IN ? WALK : IDLE;
    else                 w_next = w_last ? IDLE : WALK;
  end
  // outputs from registered state only; copy bus is zero outside a walk
  always_comb begin
    Recover_busy_OUT = r_state == WALK;
    Copy_valid_OUT   = r_state == WALK;
    Copy_arch_OUT    = Copy_valid_OUT ? r_idx : '0;
    Copy_phys_OUT    = Copy_valid_OUT ? r_map[r_idx] : '0;
    Stall_OUT        = w_full | (r_state == WALK);
  end

  free_reg_fifo #(.WIDTH(LOG_PHYS), .DEPTH(FREE_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .o_valid (Free_valid_OUT),
    .o_data  (Free_reg_OUT),
    .i_ready (Free_ready_IN),
    .o_full  (w_full)
  );
endmodule

// File: tb/tb_retire_rat.sv
// tb_retire_rat: scoreboard bench for retire_rat (free-register queue and walk snapshot model)
module tb_retire_rat;
  localparam int NA = 32, NP = 64, FD = 8;
  logic       CLK = 0, RESET = 1;
  logic       Commit_valid_IN = 0, Free_ready_IN = 0, Recover_IN = 0;
  logic [4:0] Commit_arch_IN = 0;
  logic [5:0] Commit_phys_IN = 0;
  logic       Stall_OUT, Free_valid_OUT, Recover_busy_OUT, Copy_valid_OUT;
  logic [5:0] Free_reg_OUT, Copy_phys_OUT;
  logic [4:0] Copy_arch_OUT;
  int         n_vec = 0, n_err = 0;
  logic [5:0] m_map [NA];
  logic [5:0] m_snap [NA];
  logic [5:0] m_q [$];
  bit         m_walk;
  int         m_idx;

  always #5 CLK = ~CLK;

  retire_rat #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .FREE_DEPTH(FD)) dut (
    .CLK(CLK), .RESET(RESET),
    .Commit_valid_IN(Commit_valid_IN), .Commit_arch_IN(Commit_arch_IN), .Commit_phys_IN(Commit_phys_IN),
    .Stall_OUT(Stall_OUT),
    .Free_valid_OUT(Free_valid_OUT), .Free_reg_OUT(Free_reg_OUT), .Free_ready_IN(Free_ready_IN),
    .Recover_IN(Recover_IN), .Recover_busy_OUT(Recover_busy_OUT),
    .Copy_valid_OUT(Copy_valid_OUT), .Copy_arch_OUT(Copy_arch_OUT), .Copy_phys_OUT(Copy_phys_OUT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    foreach (m_map[i]) m_map[i] = 6'(i);
    m_q.delete();
    m_walk = 0;
    m_idx  = 0;
  endtask

  task automatic checkzero();
    check("rst_stall", Stall_OUT, 0);
    check("rst_fvalid", Free_valid_OUT, 0);
    check("rst_freg", Free_reg_OUT, 0);
    check("rst_busy", Recover_busy_OUT, 0);
    check("rst_cvalid", Copy_valid_OUT, 0);
    check("rst_carch", Copy_arch_OUT, 0);
    check("rst_cphys", Copy_phys_OUT, 0);
  endtask

  task automatic cycle();
    bit acc, pop;
    logic [5:0] old;
    @(negedge CLK);
    check("stall", Stall_OUT, (m_q.size() == FD) || m_walk);
    check("fvalid", Free_valid_OUT, m_q.size() != 0);
    check("busy", Recover_busy_OUT, m_walk);
    check("cvalid", Copy_valid_OUT, m_walk);
    if (m_q.size() != 0) check("freg", Free_reg_OUT, m_q[0]);
    if (m_walk) begin
      check("carch", Copy_arch_OUT, m_idx);
      check("cphys", Copy_phys_OUT, m_snap[m_idx]);
    end
    acc = Commit_valid_IN && !((m_q.size() == FD) || m_walk);
    pop = Free_ready_IN && m_q.size() != 0;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      old = m_map[Commit_arch_IN];
`ifdef RRAT_ZERO_REG_EN
      if (Commit_arch_IN == 0) m_q.push_back(Commit_phys_IN);
      else
`endif
      begin
        if (old != Commit_phys_IN) m_q.push_back(old);
        m_map[Commit_arch_IN] = Commit_phys_IN;
      end
    end
    if (m_walk) begin
      m_idx++;
      if (m_idx == NA) begin
        m_walk = 0;
        m_idx  = 0;
      end
    end else if (Recover_IN) begin
      m_walk = 1;
      m_idx  = 0;
      m_snap = m_map;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic commit(input int a, input int p);
    Commit_valid_IN = 1;
    Commit_arch_IN  = 5'(a);
    Commit_phys_IN  = 6'(p);
    cycle();
    Commit_valid_IN = 0;
  endtask

  task automatic walk();
    Recover_IN = 1;
    cycle();
    Recover_IN = 0;
    repeat (NA + 2) cycle();
  endtask

  initial begin
    mreset();
    #1 RESET = 0;
    #2 checkzero();
    @(negedge CLK) RESET = 1;
    @(posedge CLK);
    #1;
    walk();
    Free_ready_IN = 1;
    commit(5, 40);
    repeat (2) cycle();
    walk();
    Free_ready_IN = 0;
    for (int i = 0; i < 8; i++) commit(8 + i, 41 + i);
    Commit_valid_IN = 1;
    Commit_arch_IN  = 7;
    Commit_phys_IN  = 50;
    repeat (3) cycle();
    Free_ready_IN = 1;
    cycle();
    Free_ready_IN = 0;
    cycle();
    Commit_valid_IN = 0;
    Free_ready_IN = 1;
    repeat (10) cycle();
    walk();
    Commit_valid_IN = 1;
    Commit_arch_IN  = 3;
    Commit_phys_IN  = 60;
    Recover_IN      = 1;
    cycle();
    Recover_IN     = 0;
    Commit_arch_IN = 4;
    Commit_phys_IN = 61;
    repeat (NA + 2) cycle();
    Commit_valid_IN = 0;
    walk();
    repeat (80) begin
      Commit_valid_IN = 1'($urandom_range(1));
      Commit_arch_IN  = 5'($urandom_range(NA - 1));
      Commit_phys_IN  = 6'($urandom_range(NP - 1));
      Free_ready_IN   = $urandom_range(3) != 0;
      Recover_IN      = $urandom_range(15) == 0;
      cycle();
    end
    Commit_valid_IN = 0;
    Recover_IN      = 0;
    Free_ready_IN   = 1;
    repeat (NA + 2) cycle();
    walk();
    commit(10, 33);
    Recover_IN = 1;
    cycle();
    Recover_IN = 0;
    for (int k = 0; k < NA + 4 && m_idx != 10; k++) cycle();
    check("walk_at_10", m_idx, 10);
    #2 RESET = 0;
    #1 checkzero();
    mreset();
    @(negedge CLK) RESET = 1;
    @(posedge CLK);
    #1;
    walk();
    Free_ready_IN = 0;
    commit(0, 45);
    repeat (2) cycle();
    walk();
    Free_ready_IN = 1;
    repeat (4) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
